// File: rtl/imem_load_if.sv
// ---------------------------------------------------------------------------
// imem_load_if
// Purpose : Bundles the loader byte stream, the start/count request, the
//           instruction-memory write port and the CPU hold/status lines used
//           by imem_load_controller.
// Ports (signals in the bundle):
//   start       1       1-cycle request to begin a load
//   load_count  ADDR_W  number of words to load, sampled on accepted start
//   byte_valid  1       byte_data is valid
//   byte_data   8       stream byte, high byte of each word first
//   byte_ready  1       controller accepts a byte this cycle
//   im_we       1       IM write strobe, one cycle per word
//   im_addr     ADDR_W  IM write address
//   im_wdata    DATA_W  IM write data
//   cpu_hold    1       stall PC/fetch while high
//   busy        1       load in progress
//   done        1       1-cycle pulse at load completion
//   err         1       sticky error flag
// Modports: slave = controller side, master = loader/system side.
// ---------------------------------------------------------------------------
interface imem_load_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] load_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, load_count, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
  );

  modport master (
    output start, load_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_load_controller.sv
// ---------------------------------------------------------------------------
// imem_load_controller
// Purpose : Boot-time loader for the 16-bit instruction memory. Assembles
//           pairs of stream bytes (high byte first) into words, writes them
//           to consecutive IM addresses starting at 0, and keeps the CPU
//           stalled for the whole load.
// Ports   :
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous reset, active-low
//   bus    imem_load_if.slave : start/load_count request, byte stream
//          handshake, IM write port, cpu_hold/busy/done/err status
// Options :
//   IMLOAD_CHECKSUM_EN  when defined, two checksum bytes (high first) follow
//                       the last word; a mismatch against the 16-bit modulo
//                       sum of the written words raises err together with
//                       done. Undefined: FINISH follows the last WRITE.
// ---------------------------------------------------------------------------
module imem_load_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_load_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_HI,
    S_GET_LO,
    S_WRITE,
    S_CSUM,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_word;
  logic              r_byte_ready;
  logic              r_im_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef IMLOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [7:0]        r_csum_hi;
  logic              r_csum_lo;
`endif

  logic w_xfer;

  assign w_xfer = bus.byte_valid & r_byte_ready;

  assign bus.byte_ready = r_byte_ready;
  assign bus.im_we      = r_im_we;
  assign bus.im_addr    = r_addr;
  assign bus.im_wdata   = r_word;
  assign bus.busy       = r_busy;
  assign bus.cpu_hold   = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

  // Single FSM; every output is a register set on the transition into the
  // state that owns it, so byte_ready/im_we/done line up exactly with the
  // GET_*/WRITE/FINISH states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_byte_ready <= 1'b0;
      r_im_we      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IMLOAD_CHECKSUM_EN
      r_sum        <= '0;
      r_csum_hi    <= '0;
      r_csum_lo    <= 1'b0;
`endif
    end else begin
      r_im_we <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.load_count == '0) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
              r_err   <= 1'b0;
            end else if (bus.load_count > ADDR_W'(DEPTH)) begin
              // Oversized request: flag it but never take the CPU off-line.
              r_err <= 1'b1;
            end else begin
              r_state      <= S_GET_HI;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
              r_count      <= bus.load_count;
              r_addr       <= '0;
              r_err        <= 1'b0;
`ifdef IMLOAD_CHECKSUM_EN
              r_sum        <= '0;
`endif
            end
          end
        end
        S_GET_HI: begin
          if (w_xfer) begin
            r_word[DATA_W-1 -: 8] <= bus.byte_data;
            r_state               <= S_GET_LO;
          end
        end
        S_GET_LO: begin
          if (w_xfer) begin
            r_word[7:0]  <= bus.byte_data;
            r_state      <= S_WRITE;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b1;
          end
        end
        S_WRITE: begin
`ifdef IMLOAD_CHECKSUM_EN
          r_sum <= r_sum + r_word;
`endif
          // The start check bounds count to DEPTH, so addr never wraps.
          if (r_addr == r_count - ADDR_W'(1)) begin
`ifdef IMLOAD_CHECKSUM_EN
            r_state      <= S_CSUM;
            r_byte_ready <= 1'b1;
            r_csum_lo    <= 1'b0;
`else
            r_state <= S_FINISH;
            r_done  <= 1'b1;
`endif
          end else begin
            r_addr       <= r_addr + ADDR_W'(1);
            r_state      <= S_GET_HI;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef IMLOAD_CHECKSUM_EN
        S_CSUM: begin
          // Two bytes, high first; the sum already includes the last word
          // because WRITE always precedes CSUM by at least one cycle.
          if (w_xfer) begin
            if (!r_csum_lo) begin
              r_csum_hi <= bus.byte_data;
              r_csum_lo <= 1'b1;
            end else begin
              r_state      <= S_FINISH;
              r_byte_ready <= 1'b0;
              r_done       <= 1'b1;
              r_err        <= ({r_csum_hi, bus.byte_data} != r_sum[15:0]);
            end
          end
        end
`endif
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
// ---------------------------------------------------------------------------
// tb_imem_load_controller
// Purpose : Self-checking bench for imem_load_controller. A reference model
//           turns each requested load into the list of words that must land
//           in IM (address i gets word i) plus the expected err/done outcome;
//           a random-valid byte driver and a write monitor run alongside.
// Options : IMLOAD_CHECKSUM_EN adds checksum bytes to each load and the
//           directed checksum match/mismatch cases.
// ---------------------------------------------------------------------------
module tb_imem_load_controller;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  imem_load_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

  imem_load_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [7:0]  txBytes[$];
  logic [15:0] planWords[$];
  logic [31:0] gotWrites[$];
  int          validPct    = 100;
  int          doneCount   = 0;
  logic        prevReady   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte source: a byte leaves the queue once the posedge after a negedge
  // with valid & ready has passed; invalid cycles carry junk data.
  always @(negedge clk) begin
    logic [7:0] dropped;
    if (u_if.byte_valid === 1'b1 && prevReady === 1'b1 && txBytes.size() > 0)
      dropped = txBytes.pop_front();
    prevReady = u_if.byte_ready;
    if (txBytes.size() > 0 && $urandom_range(99) < validPct) begin
      u_if.byte_valid = 1'b1;
      u_if.byte_data  = txBytes[0];
    end else begin
      u_if.byte_valid = 1'b0;
      u_if.byte_data  = 8'($urandom);
    end
  end

  // Write/done monitor.
  always @(negedge clk) begin
    if (u_if.im_we === 1'b1) begin
      gotWrites.push_back({8'h00, u_if.im_addr, u_if.im_wdata});
      checkOutput("we_while_busy", {31'd0, u_if.busy}, 32'd1);
    end
    if (u_if.done === 1'b1) doneCount++;
  end

  task automatic applyStimulus(input int count, input int pct, input int csumDelta,
                               input bit noisy, input string tag);
    logic [15:0] words[$];
    logic [15:0] w;
    logic [15:0] sum;
    logic [15:0] csum;
    logic        expErr;
    logic        errAtDone;
    bit          doneSeen;
    int          cycles;
    int          startDone;

    sum = 16'h0000;
    if (count >= 1 && count <= DEPTH) begin
      for (int i = 0; i < count; i++) begin
        w = (i < planWords.size()) ? planWords[i] : 16'($urandom);
        words.push_back(w);
        sum = sum + w;
        txBytes.push_back(w[15:8]);
        txBytes.push_back(w[7:0]);
      end
    end
`ifdef IMLOAD_CHECKSUM_EN
    if (count >= 1 && count <= DEPTH) begin
      csum = sum + 16'(csumDelta);
      txBytes.push_back(csum[15:8]);
      txBytes.push_back(csum[7:0]);
    end
    expErr = (count >= 1 && count <= DEPTH && csumDelta != 0);
`else
    csum   = 16'(csumDelta);
    expErr = 1'b0;
`endif

    validPct = pct;
    gotWrites.delete();
    startDone = doneCount;

    @(negedge clk);
    u_if.start      = 1'b1;
    u_if.load_count = 8'(count);
    @(negedge clk);
    u_if.start      = 1'b0;
    u_if.load_count = 8'($urandom);

    if (count > DEPTH) begin
      checkOutput({tag, "_err"}, {31'd0, u_if.err}, 32'd1);
      checkOutput({tag, "_busy"}, {31'd0, u_if.busy}, 32'd0);
      checkOutput({tag, "_hold"}, {31'd0, u_if.cpu_hold}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput({tag, "_writes"}, gotWrites.size(), 32'd0);
      checkOutput({tag, "_done"}, doneCount - startDone, 32'd0);
      checkOutput({tag, "_errSticky"}, {31'd0, u_if.err}, 32'd1);
      return;
    end

    checkOutput({tag, "_busy1"}, {31'd0, u_if.busy}, 32'd1);
    checkOutput({tag, "_hold1"}, {31'd0, u_if.cpu_hold}, 32'd1);
    if (count == 0) checkOutput({tag, "_doneNow"}, {31'd0, u_if.done}, 32'd1);

    doneSeen  = (u_if.done === 1'b1);
    errAtDone = u_if.err;
    cycles    = 0;
    while (!doneSeen && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      u_if.start = 1'b0;
      doneSeen   = (u_if.done === 1'b1);
      errAtDone  = u_if.err;
      if (!doneSeen && noisy && $urandom_range(9) == 0) begin
        u_if.start      = 1'b1;
        u_if.load_count = 8'($urandom);
      end
    end
    u_if.start = 1'b0;

    checkOutput({tag, "_timeout"}, {31'd0, doneSeen}, 32'd1);
    checkOutput({tag, "_errAtDone"}, {31'd0, errAtDone}, {31'd0, expErr});
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, {31'd0, u_if.done}, 32'd0);
    checkOutput({tag, "_holdAfter"}, {31'd0, u_if.cpu_hold}, 32'd0);
    checkOutput({tag, "_busyAfter"}, {31'd0, u_if.busy}, 32'd0);
    checkOutput({tag, "_doneCnt"}, doneCount - startDone, 32'd1);
    checkOutput({tag, "_nWrites"}, gotWrites.size(), words.size());
    for (int i = 0; i < words.size(); i++) begin
      if (i < gotWrites.size())
        checkOutput({tag, "_wr"}, gotWrites[i], {8'h00, 8'(i), words[i]});
    end
    checkOutput({tag, "_leftover"}, txBytes.size(), 32'd0);
    checkOutput({tag, "_errSticky"}, {31'd0, u_if.err}, {31'd0, expErr});
  endtask

  initial begin
    logic [15:0] w0;
    int          d0;
    int          cycles;
    int          cnt;
    int          delta;

    u_if.start      = 1'b0;
    u_if.load_count = '0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_busy",   {31'd0, u_if.busy},       32'd0);
    checkOutput("rst_hold",   {31'd0, u_if.cpu_hold},   32'd0);
    checkOutput("rst_done",   {31'd0, u_if.done},       32'd0);
    checkOutput("rst_err",    {31'd0, u_if.err},        32'd0);
    checkOutput("rst_ready",  {31'd0, u_if.byte_ready}, 32'd0);
    checkOutput("rst_we",     {31'd0, u_if.im_we},      32'd0);
    checkOutput("rst_addr",   {24'd0, u_if.im_addr},    32'd0);
    checkOutput("rst_wdata",  {16'd0, u_if.im_wdata},   32'd0);
    rst_n = 1'b1;

    planWords = '{16'h1234, 16'hABCD};
    applyStimulus(2, 100, 0, 1'b0, "t1");
    planWords.delete();

    applyStimulus(0, 100, 0, 1'b0, "t2");
    applyStimulus(31, 100, 0, 1'b0, "t3");
    applyStimulus(30, 50, 0, 1'b1, "t4");

    // Reset in the middle of a 4-word load, right after the first write.
    w0 = 16'($urandom);
    txBytes.push_back(w0[15:8]);
    txBytes.push_back(w0[7:0]);
    for (int i = 0; i < 6; i++) txBytes.push_back(8'($urandom));
    validPct = 100;
    gotWrites.delete();
    d0 = doneCount;
    @(negedge clk);
    u_if.start      = 1'b1;
    u_if.load_count = 8'd4;
    @(negedge clk);
    u_if.start = 1'b0;
    cycles = 0;
    while (gotWrites.size() == 0 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("t5_firstWrite", {31'd0, gotWrites.size() > 0}, 32'd1);
    rst_n = 1'b0;
    txBytes.delete();
    @(negedge clk);
    checkOutput("t5_busy",  {31'd0, u_if.busy},       32'd0);
    checkOutput("t5_hold",  {31'd0, u_if.cpu_hold},   32'd0);
    checkOutput("t5_ready", {31'd0, u_if.byte_ready}, 32'd0);
    checkOutput("t5_we",    {31'd0, u_if.im_we},      32'd0);
    checkOutput("t5_done",  {31'd0, u_if.done},       32'd0);
    checkOutput("t5_addr",  {24'd0, u_if.im_addr},    32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t5_nWrites", gotWrites.size(), 32'd1);
    if (gotWrites.size() > 0) checkOutput("t5_wr0", gotWrites[0], {16'h0000, w0});
    checkOutput("t5_noDone", doneCount - d0, 32'd0);
    checkOutput("t5_idle",   {31'd0, u_if.busy}, 32'd0);

`ifdef IMLOAD_CHECKSUM_EN
    planWords = '{16'h0001, 16'h0002};
    applyStimulus(2, 100, 0, 1'b0, "t6_match");
    applyStimulus(2, 100, 1, 1'b0, "t6_bad");
    planWords.delete();
`endif

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(7))
        0:       cnt = 0;
        1:       cnt = $urandom_range(255, DEPTH + 1);
        default: cnt = $urandom_range(DEPTH, 1);
      endcase
      delta = ($urandom_range(2) == 0) ? $urandom_range(65535, 1) : 0;
      applyStimulus(cnt, $urandom_range(100, 30), delta, 1'($urandom_range(1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
